arm_prefetch_unit: RTL and testbench

Parametrised instruction front-end for the pipelined ARM core. It replaces the single-register fetch stage with a PC generator feeding a DEPTH-entry prefetch queue. The queue decouples instruction-memory reads from decode stalls, and it is flushed and redirected on taken branches or PC writes. It sits between instruction memory and the decode stage and exports each instruction together with its PC+8 value, as decode requires for R15 reads.

---
 rtl/arm_prefetch_unit.sv | 162 ++++++++++++++++
 tb/tb_arm_prefetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_prefetch_unit.sv
// ============================================================================
// arm_prefetch_unit
// ----------------------------------------------------------------------------
// Instruction front-end for the pipelined ARM core. A PC generator issues one
// word fetch per cycle into a DEPTH-entry prefetch queue. The queue separates
// instruction-memory reads from decode stalls. Every entry carries the
// instruction and its fetch address + 8, which is the value decode returns for
// R15 reads. A taken branch or PC write (i_redirect) flushes the queue and
// restarts fetching at the new address.
//
// Parameters
//   DATA_W    instruction width
//   ADDR_W    PC / address width
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  fetch address after reset (word aligned)
//
// Ports
//   i_clk           clock, all state changes on the rising edge
//   i_reset         synchronous active-high reset
//   o_imem_addr     fetch address (the internal fetch PC)
//   o_imem_req      a fetch happens this cycle; i_imem_data is captured at
//                   the next edge
//   i_imem_data     instruction at o_imem_addr (combinational memory)
//   i_redirect      taken branch / PC write from a later stage
//   i_redirect_pc   new fetch address, bits [1:0] ignored
//   o_deq_valid     queue head holds a valid instruction
//   i_deq_ready     decode accepts the head this cycle
//   o_deq_instr     head instruction
//   o_deq_pc_plus8  head fetch address + 8
//   o_count         occupied entries, 0..DEPTH
// ============================================================================
module arm_prefetch_unit #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  output logic [ADDR_W-1:0]          o_imem_addr,
  output logic                       o_imem_req,
  input  logic [DATA_W-1:0]          i_imem_data,
  input  logic                       i_redirect,
  input  logic [ADDR_W-1:0]          i_redirect_pc,
  output logic                       o_deq_valid,
  input  logic                       i_deq_ready,
  output logic [DATA_W-1:0]          o_deq_instr,
  output logic [ADDR_W-1:0]          o_deq_pc_plus8,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Architectural state
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Queue storage; deliberately not reset, since count alone defines validity
  logic [DATA_W-1:0] r_instr_q [DEPTH];
  logic [ADDR_W-1:0] r_pc8_q   [DEPTH];

  // Handshake and next-state wires
  logic              w_full;
  logic              w_deq_valid;
  logic              w_deq;
  logic              w_enq;
  logic [ADDR_W-1:0] w_redirect_pc_aligned;
  logic [ADDR_W-1:0] w_fetch_pc_plus4;
  logic [ADDR_W-1:0] w_fetch_pc_plus8;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_count_nxt;

  // --------------------------------------------------------------------------
  // Handshake. The head is hidden during a redirect so decode can never take a
  // wrong-path instruction. A full queue can still accept a fetch when the
  // head leaves in the same cycle. Reset and redirect both suppress the fetch.
  // --------------------------------------------------------------------------
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_deq_valid = (r_count != {CNT_W{1'b0}}) & ~i_redirect;
  assign w_deq       = w_deq_valid & i_deq_ready;
  assign w_enq       = ~i_reset & ~i_redirect & (~w_full | w_deq);

  // The mask keeps every bit of i_redirect_pc in use while forcing word alignment
  assign w_redirect_pc_aligned = i_redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};

  // PC arithmetic wraps modulo 2^ADDR_W on purpose: no overflow detection
  assign w_fetch_pc_plus4 = r_fetch_pc + ADDR_W'(4);
  assign w_fetch_pc_plus8 = r_fetch_pc + ADDR_W'(8);

  // Next-state logic for PC, pointers and occupancy. Redirect overrides enq/deq.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_count_nxt    = r_count;

    if (i_redirect) begin
      // Flush: read pointer jumps to the write pointer, stale entries remain
      // in storage but become unreachable
      w_fetch_pc_nxt = w_redirect_pc_aligned;
      w_rd_ptr_nxt   = r_wr_ptr;
      w_count_nxt    = {CNT_W{1'b0}};
    end else begin
      if (w_enq) begin
        w_fetch_pc_nxt = w_fetch_pc_plus4;
        w_wr_ptr_nxt   = r_wr_ptr + PTR_W'(1);
      end else begin
        w_fetch_pc_nxt = r_fetch_pc;
        w_wr_ptr_nxt   = r_wr_ptr;
      end

      if (w_deq) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end

      case ({w_enq, w_deq})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // State registers with synchronous reset. Reset takes priority over redirect.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // Queue write port: capture the fetched word together with its PC+8 tag
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_instr_q[r_wr_ptr] <= i_imem_data;
      r_pc8_q[r_wr_ptr]   <= w_fetch_pc_plus8;
    end
  end

  // Outputs. There is no bypass path, so the head always comes from storage.
  assign o_imem_addr    = r_fetch_pc;
  assign o_imem_req     = w_enq;
  assign o_deq_valid    = w_deq_valid;
  assign o_deq_instr    = r_instr_q[r_rd_ptr];
  assign o_deq_pc_plus8 = r_pc8_q[r_rd_ptr];
  assign o_count        = r_count;

endmodule

// File: tb/tb_arm_prefetch_unit.sv
module tb_arm_prefetch_unit;

  localparam int          DEPTH   = 4;
  localparam int          CW      = 3;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1 (RESET_PC = 0)
  logic          rst = 1'b1, redir = 1'b0, rdy = 1'b0;
  logic [31:0]   rpc = 32'h0, mem_xor = 32'h0;
  logic [31:0]   imem_addr, imem_data, instr, pc8;
  logic          req, valid;
  logic [CW-1:0] count;
  assign imem_data = imem_addr ^ mem_xor;

  // DUT 2 (RESET_PC at the top word, for wrap checks)
  logic          rst2 = 1'b1, rdy2 = 1'b1;
  logic [31:0]   addr2, data2, instr2, pc82;
  logic          req2, valid2;
  logic [CW-1:0] count2;
  assign data2 = addr2;

  arm_prefetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_clk(clk), .i_reset(rst), .o_imem_addr(imem_addr), .o_imem_req(req),
    .i_imem_data(imem_data), .i_redirect(redir), .i_redirect_pc(rpc),
    .o_deq_valid(valid), .i_deq_ready(rdy), .o_deq_instr(instr),
    .o_deq_pc_plus8(pc8), .o_count(count));

  arm_prefetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(RST_PC2)) dut2 (
    .i_clk(clk), .i_reset(rst2), .o_imem_addr(addr2), .o_imem_req(req2),
    .i_imem_data(data2), .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_deq_valid(valid2), .i_deq_ready(rdy2), .o_deq_instr(instr2),
    .o_deq_pc_plus8(pc82), .o_count(count2));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of {instr, pc+8} plus the fetch address
  logic [63:0]  mq[$];
  logic [31:0]  m_pc = 32'h0;
  logic         m_valid, m_deq, m_enq;
  logic [100:0] exp_vec;

  function automatic logic [100:0] obs_vec();
    return {valid, req, count, imem_addr, valid ? instr : 32'h0, valid ? pc8 : 32'h0};
  endfunction

  // Apply inputs for this cycle and derive the expected outputs from the model
  task automatic drive(input logic r, input logic rd, input logic [31:0] p, input logic dr);
    logic [63:0] head;
    rst = r; redir = rd; rpc = p; rdy = dr;
    #2;
    m_valid = (mq.size() != 0) && !rd;
    m_deq   = m_valid && dr;
    m_enq   = !r && !rd && ((mq.size() < DEPTH) || m_deq);
    head    = m_valid ? mq[0] : 64'h0;
    exp_vec = {m_valid, m_enq, CW'(mq.size()), m_pc, head[63:32], head[31:0]};
  endtask

  // Advance one clock and update the model with the same rules
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_pc = RST_PC;
    end else if (redir) begin
      mq.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (m_deq) void'(mq.pop_front());
      if (m_enq) begin
        mq.push_back({m_pc ^ mem_xor, m_pc + 32'd8});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if ({count, req, valid, imem_addr} !== {3'd0, 1'b0, 1'b0, RST_PC}) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d req=%b valid=%b addr=%h, want 0 0 0 %h",
               count, req, valid, imem_addr, RST_PC);
    end
    tick();
  endtask

  task automatic test_stream();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({req, imem_addr} !== {1'b1, RST_PC}) begin
      n_fail++;
      $display("FAIL release_fetch: req=%b addr=%h, want 1 %h", req, imem_addr, RST_PC);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if ({valid, instr, pc8, count} !== {1'b1, 32'(4*i), 32'(4*i+8), 3'd1}) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%b instr=%h pc8=%h count=%0d, want 1 %h %h 1",
                 i, valid, instr, pc8, count, 32'(4*i), 32'(4*i+8));
      end
      n_checks++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL stream_model[%0d]: got %h want %h", i, obs_vec(), exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_fill_drain();
    drive(1'b1, 1'b0, 32'h0, 1'b0); tick();
    for (int c = 1; c <= 6; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      if (c >= 5) begin
        n_checks++;
        if ({req, imem_addr} !== {1'b0, 32'h10}) begin
          n_fail++;
          $display("FAIL full_stall[%0d]: req=%b addr=%h, want 0 00000010", c, req, imem_addr);
        end
      end
      tick();
      n_checks++;
      if (count !== CW'(c > DEPTH ? DEPTH : c)) begin
        n_fail++;
        $display("FAIL fill_count[%0d]: count=%0d want %0d", c, count, (c > DEPTH ? DEPTH : c));
      end
    end
    // Full with simultaneous dequeue
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({req, valid, instr, imem_addr} !== {1'b1, 1'b1, 32'h0, 32'h10}) begin
      n_fail++;
      $display("FAIL full_deq: req=%b valid=%b instr=%h addr=%h, want 1 1 0 10",
               req, valid, instr, imem_addr);
    end
    tick();
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_deq_count: count=%0d want 4", count);
    end
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if ({valid, instr} !== {1'b1, 32'(4*k)} || obs_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL drain[%0d]: got %h want %h (instr %h want %h)",
                 k, obs_vec(), exp_vec, instr, 32'(4*k));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 32'h0, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin drive(1'b0, 1'b0, 32'h0, 1'b0); tick(); end
    drive(1'b0, 1'b1, 32'h0000_1003, 1'b1);
    n_checks++;
    if ({count, valid, req} !== {3'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL redirect_cycle: count=%0d valid=%b req=%b, want 3 0 0", count, valid, req);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({count, valid, imem_addr} !== {3'd0, 1'b0, 32'h1000}) begin
      n_fail++;
      $display("FAIL redirect_next: count=%0d valid=%b addr=%h, want 0 0 00001000",
               count, valid, imem_addr);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({valid, instr, pc8} !== {1'b1, 32'h1000, 32'h1008}) begin
      n_fail++;
      $display("FAIL redirect_target: valid=%b instr=%h pc8=%h, want 1 00001000 00001008",
               valid, instr, pc8);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, 32'h0000_2000, 1'b1); tick();
    drive(1'b0, 1'b1, 32'h0000_300A, 1'b1); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({valid, imem_addr} !== {1'b0, 32'h3008}) begin
      n_fail++;
      $display("FAIL b2b_addr: valid=%b addr=%h, want 0 00003008", valid, imem_addr);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({valid, instr, pc8} !== {1'b1, 32'h3008, 32'h3010}) begin
      n_fail++;
      $display("FAIL b2b_head: valid=%b instr=%h pc8=%h, want 1 00003008 00003010",
               valid, instr, pc8);
    end
    tick();
  endtask

  task automatic test_reset_redirect();
    for (int c = 0; c < 3; c++) begin drive(1'b0, 1'b0, 32'h0, 1'b0); tick(); end
    drive(1'b1, 1'b1, 32'h0000_4000, 1'b1); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if ({imem_addr, count, valid} !== {RST_PC, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_redirect: addr=%h count=%0d valid=%b, want %h 0 0",
               imem_addr, count, valid, RST_PC);
    end
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    mem_xor = $urandom;
    for (int i = 0; i < 400; i++) begin
      logic r, rd, dr;
      logic [31:0] p;
      r  = ($urandom_range(0, 63) == 0);
      rd = ($urandom_range(0, 15) == 0);
      dr = ($urandom_range(0, 3) != 0);
      p  = ($urandom_range(0, 1) == 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      drive(r, rd, p, dr);
      n_checks++;
      if (obs_vec() !== exp_vec) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec);
      end
      tick();
    end
    mem_xor = 32'h0;
  endtask

  task automatic test_wrap();
    rst2 = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if ({req2, addr2} !== {1'b1, RST_PC2}) begin
      n_fail++;
      $display("FAIL wrap_first: req=%b addr=%h, want 1 %h", req2, addr2, RST_PC2);
    end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if ({addr2, valid2, instr2, pc82} !== {32'h0, 1'b1, RST_PC2, 32'h4}) begin
      n_fail++;
      $display("FAIL wrap_second: addr=%h valid=%b instr=%h pc8=%h, want 0 1 %h 4",
               addr2, valid2, instr2, pc82, RST_PC2);
    end
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if ({addr2, valid2, instr2, pc82, count2} !== {32'h4, 1'b1, 32'h0, 32'h8, 3'd1}) begin
      n_fail++;
      $display("FAIL wrap_third: addr=%h valid=%b instr=%h pc8=%h count=%0d, want 4 1 0 8 1",
               addr2, valid2, instr2, pc82, count2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_drain();
    test_redirect();
    test_back_to_back();
    test_reset_redirect();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
